// File: rtl/wr_line_buf_pkg.sv
// Shared types and constants for the write-side line buffer.
package wr_line_buf_pkg;

    typedef enum logic [2:0] {IDLE, FILL, REQ, XFER, NEXT} state_t;

    localparam int RAM_WIDTH = 128;
    localparam int BUF_DEPTH = 1024;
    localparam int RAM_AW    = 10;
    localparam int PTR_WIDTH = RAM_AW + 1;

    function automatic int calc_line_beats(input int h_num, input int pix_width);
        return h_num * pix_width / RAM_WIDTH;
    endfunction

    function automatic int calc_addr_step(input int line_beats, input int dq_width);
        return line_beats * RAM_WIDTH / dq_width;
    endfunction

endpackage

// File: rtl/wr_line_buf_ram.sv
// 1024x128 simple dual-port ring storage with a registered read port.
module wr_line_ram
    import wr_line_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [RAM_AW-1:0]    waddr,
    input  logic [RAM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [RAM_AW-1:0]    raddr,
    output logic [RAM_WIDTH-1:0] rdata
);

    logic [RAM_WIDTH-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wr_line_buf.sv
// Write-side line buffer: buffers pixel beats, bursts one line at a time to DDR.
// Optional WR_BUF_ABORT_CNT_EN adds a saturating abort counter output.
module wr_line_buf
    import wr_line_buf_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 27,
    parameter logic [31:0] ADDR_OFFSET     = 32'h0,
    parameter int          H_NUM           = 1920,
    parameter int          V_NUM           = 1080,
    parameter int          DQ_WIDTH        = 16,
    parameter int          LEN_WIDTH       = 16,
    parameter int          PIX_WIDTH       = 24,
    parameter int          LINE_ADDR_WIDTH = 22
) (
    input  logic                    ddr_clk,
    input  logic                    ddr_rst,
    input  logic                    init_done,
    input  logic                    vin_fsync,
    input  logic                    vin_valid,
    output logic                    vin_ready,
    input  logic [RAM_WIDTH-1:0]    vin_data,
    output logic                    ddr_wreq,
    output logic [ADDR_WIDTH-1:0]   ddr_waddr,
    output logic [LEN_WIDTH-1:0]    ddr_wr_len,
    input  logic                    ddr_wrdy,
    input  logic                    ddr_wdone,
    input  logic                    ddr_wdata_req,
    output logic [8*DQ_WIDTH-1:0]   ddr_wdata,
    output logic                    o_wr_frame_bit,
    output logic                    o_frame_done,
    output logic                    o_frame_abort
`ifdef WR_BUF_ABORT_CNT_EN
    ,
    output logic [7:0]              o_abort_cnt
`endif
);

    localparam int LINE_BEATS = calc_line_beats(H_NUM, PIX_WIDTH);
    localparam int ADDR_STEP  = calc_addr_step(LINE_BEATS, DQ_WIDTH);
    localparam logic [PTR_WIDTH-1:0]       LB_PTR = PTR_WIDTH'(LINE_BEATS);
    localparam logic [LEN_WIDTH-1:0]       LB_LEN = LEN_WIDTH'(LINE_BEATS);
    localparam logic [LINE_ADDR_WIDTH-1:0] STEP   = LINE_ADDR_WIDTH'(ADDR_STEP);
    localparam logic [15:0]                V_LAST = 16'(V_NUM - 1);

    state_t                     state, state_nxt;
    logic [PTR_WIDTH-1:0]       wptr, rptr, fill, burst_start;
    logic [LEN_WIDTH-1:0]       beat_cnt;
    logic [15:0]                line_cnt;
    logic [LINE_ADDR_WIDTH-1:0] line_addr;
    logic                       fsync_d, wdone_d, restart_pend;
    logic                       fsync_rise, wdone_rise, push, pop;
    logic                       flush, start_burst, end_burst, next_line;
    logic                       done_set, abort_set, pend_set, pend_clr;
    logic [RAM_WIDTH-1:0]       ram_rdata;

    assign fsync_rise = vin_fsync & ~fsync_d;
    assign wdone_rise = ddr_wdone & ~wdone_d;
    assign fill       = wptr - rptr;
    assign vin_ready  = (state != IDLE) && !restart_pend && !fill[PTR_WIDTH-1];
    assign push       = vin_valid & vin_ready;
    assign pop        = (state == XFER) && ddr_wdata_req && (beat_cnt < LB_LEN);

    assign ddr_wreq   = (state == REQ);
    assign ddr_wr_len = LB_LEN;
    assign ddr_waddr  = ADDR_WIDTH'({o_wr_frame_bit, line_addr}) + ADDR_WIDTH'(ADDR_OFFSET);
    assign ddr_wdata  = (8*DQ_WIDTH)'(ram_rdata);

    always_comb begin
        state_nxt   = state;
        flush       = 1'b0;
        start_burst = 1'b0;
        end_burst   = 1'b0;
        next_line   = 1'b0;
        done_set    = 1'b0;
        abort_set   = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (fsync_rise && init_done) begin
                    flush     = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (fsync_rise) begin
                    flush     = 1'b1;
                    abort_set = 1'b1;
                end else if (fill >= LB_PTR) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                pend_set = fsync_rise;
                if (ddr_wrdy) begin
                    start_burst = 1'b1;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                pend_set = fsync_rise;
                if (wdone_rise) begin
                    end_burst = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                // A sync seen during the burst restarts the frame in the same bank.
                if (restart_pend || fsync_rise) begin
                    abort_set = 1'b1;
                    flush     = 1'b1;
                    pend_clr  = 1'b1;
                    state_nxt = FILL;
                end else if (line_cnt == V_LAST) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    next_line = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            burst_start    <= '0;
            beat_cnt       <= '0;
            line_cnt       <= '0;
            line_addr      <= '0;
            fsync_d        <= 1'b0;
            wdone_d        <= 1'b0;
            restart_pend   <= 1'b0;
            o_wr_frame_bit <= 1'b0;
            o_frame_done   <= 1'b0;
            o_frame_abort  <= 1'b0;
        end else begin
            state         <= state_nxt;
            fsync_d       <= vin_fsync;
            wdone_d       <= ddr_wdone;
            o_frame_done  <= done_set;
            o_frame_abort <= abort_set;

            if (flush)     wptr <= '0;
            else if (push) wptr <= wptr + 1'b1;

            // Burst end realigns the read side even if beats were skipped or over-requested.
            if (flush)          rptr <= '0;
            else if (end_burst) rptr <= burst_start + LB_PTR;
            else if (pop)       rptr <= rptr + 1'b1;

            if (start_burst) begin
                beat_cnt    <= '0;
                burst_start <= rptr;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (flush) begin
                line_cnt  <= '0;
                line_addr <= '0;
            end else if (next_line) begin
                line_cnt  <= line_cnt + 1'b1;
                line_addr <= line_addr + STEP;
            end

            if (pend_clr)      restart_pend <= 1'b0;
            else if (pend_set) restart_pend <= 1'b1;

            if (done_set) o_wr_frame_bit <= ~o_wr_frame_bit;
        end
    end

`ifdef WR_BUF_ABORT_CNT_EN
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            o_abort_cnt <= '0;
        end else if (o_frame_abort && (o_abort_cnt != 8'hFF)) begin
            o_abort_cnt <= o_abort_cnt + 1'b1;
        end
    end
`endif

    wr_line_ram u_ram (
        .clk   (ddr_clk),
        .rst   (ddr_rst),
        .we    (push),
        .waddr (wptr[RAM_AW-1:0]),
        .wdata (vin_data),
        .re    (pop),
        .raddr (rptr[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_wr_line_buf.sv
// Scoreboard bench for wr_line_buf: small 16x4 frame DUT plus a tall-frame DUT for backpressure.
module tb_wr_line_buf;

    localparam int LB = 3;

    logic         clock = 1'b0;
    logic         ddrRst, initDone, vinFsync, vinValid, ddrWrdy, ddrWdone, ddrWdataReq;
    logic [127:0] vinData;
    logic         useBp;

    logic         readyA, wreqA, frameBitA, doneA, abortA;
    logic [26:0]  waddrA;
    logic [15:0]  lenA;
    logic [127:0] wdataA;
    logic         readyB, wreqB, frameBitB, doneB, abortB;
    logic [26:0]  waddrB;
    logic [15:0]  lenB;
    logic [127:0] wdataB;
`ifdef WR_BUF_ABORT_CNT_EN
    logic [7:0]   abortCntA, abortCntB;
`endif

    logic         mReady, mWreq;
    logic [26:0]  mWaddr;
    logic [15:0]  mLen;
    logic [127:0] mWdata;

    int compCnt = 0, failCnt = 0;
    int doneCnt = 0, abortCnt = 0, wreqCnt = 0;
    int acceptedCnt = 0, seq = 0;
    logic [127:0] expData [$];
    logic [26:0]  expAddr [$];

    always #5 clock = ~clock;

    assign mReady = useBp ? readyB : readyA;
    assign mWreq  = useBp ? wreqB  : wreqA;
    assign mWaddr = useBp ? waddrB : waddrA;
    assign mLen   = useBp ? lenB   : lenA;
    assign mWdata = useBp ? wdataB : wdataA;

    wr_line_buf #(.H_NUM(16), .V_NUM(4), .PIX_WIDTH(24)) dutA (
        .ddr_clk(clock), .ddr_rst(ddrRst), .init_done(initDone), .vin_fsync(vinFsync),
        .vin_valid(vinValid), .vin_ready(readyA), .vin_data(vinData),
        .ddr_wreq(wreqA), .ddr_waddr(waddrA), .ddr_wr_len(lenA), .ddr_wrdy(ddrWrdy),
        .ddr_wdone(ddrWdone), .ddr_wdata_req(ddrWdataReq), .ddr_wdata(wdataA),
        .o_wr_frame_bit(frameBitA), .o_frame_done(doneA), .o_frame_abort(abortA)
`ifdef WR_BUF_ABORT_CNT_EN
        , .o_abort_cnt(abortCntA)
`endif
    );

    wr_line_buf #(.H_NUM(16), .V_NUM(400), .PIX_WIDTH(24)) dutB (
        .ddr_clk(clock), .ddr_rst(ddrRst), .init_done(initDone), .vin_fsync(vinFsync),
        .vin_valid(vinValid), .vin_ready(readyB), .vin_data(vinData),
        .ddr_wreq(wreqB), .ddr_waddr(waddrB), .ddr_wr_len(lenB), .ddr_wrdy(ddrWrdy),
        .ddr_wdone(ddrWdone), .ddr_wdata_req(ddrWdataReq), .ddr_wdata(wdataB),
        .o_wr_frame_bit(frameBitB), .o_frame_done(doneB), .o_frame_abort(abortB)
`ifdef WR_BUF_ABORT_CNT_EN
        , .o_abort_cnt(abortCntB)
`endif
    );

    always @(negedge clock) begin
        if (doneA)  doneCnt++;
        if (abortA) abortCnt++;
        if (mWreq)  wreqCnt++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compCnt++;
        if (observed !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] makeBeat(input int s);
        return {32'(s), ~32'(s), 32'(s * 7 + 1), 32'hC0DE0000 ^ 32'(s)};
    endfunction

    task automatic doReset();
        @(posedge clock); #1;
        ddrRst = 1'b1; vinValid = 1'b0; vinFsync = 1'b0; ddrWdone = 1'b0; ddrWdataReq = 1'b0;
        repeat (4) @(posedge clock);
        #1 ddrRst = 1'b0;
        expData.delete();
        expAddr.delete();
    endtask

    task automatic pulseFsync();
        @(posedge clock); #1 vinFsync = 1'b1;
        @(posedge clock); #1 vinFsync = 1'b0;
    endtask

    // Offer beats every cycle; an accepted beat becomes an expected write beat.
    task automatic applyStimulus(input int nBeats, input int budget);
        int sent = 0;
        int cyc  = 0;
        while (sent < nBeats && cyc < budget) begin
            @(posedge clock); #1;
            vinValid = 1'b1;
            vinData  = makeBeat(seq);
            @(negedge clock);
            if (mReady) begin
                expData.push_back(vinData);
                seq++;
                sent++;
                acceptedCnt++;
            end
            cyc++;
        end
        @(posedge clock); #1 vinValid = 1'b0;
    endtask

    task automatic checkData();
        if (expData.size() == 0) checkOutput("wdata_underflow", 0, 1);
        else                     checkOutput("wdata", mWdata, expData.pop_front());
    endtask

    // DDR controller model: accept a request, pull LB beats, then pulse wdone.
    task automatic serveBursts(input int nBursts, input int abortAt);
        for (int b = 0; b < nBursts; b++) begin
            int waitCyc = 0;
            @(negedge clock);
            while (!mWreq && waitCyc < 300) begin
                @(negedge clock);
                waitCyc++;
            end
            if (!mWreq) begin
                checkOutput("wreq_timeout", 0, 1);
                return;
            end
            if (expAddr.size() > 0) checkOutput("waddr", mWaddr, expAddr.pop_front());
            checkOutput("wr_len", mLen, LB);
            for (int k = 0; k < LB; k++) begin
                @(posedge clock); #1;
                ddrWdataReq = 1'b1;
                vinFsync    = (b == abortAt) && (k == 0);
                @(negedge clock);
                if (k > 0) checkData();
            end
            @(posedge clock); #1;
            ddrWdataReq = 1'b0;
            vinFsync    = 1'b0;
            @(negedge clock);
            checkData();
            @(posedge clock); #1 ddrWdone = 1'b1;
            @(posedge clock); #1 ddrWdone = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, baseW;
        ddrRst = 1'b1; initDone = 1'b1; vinFsync = 1'b0; vinValid = 1'b0; vinData = '0;
        ddrWrdy = 1'b1; ddrWdone = 1'b0; ddrWdataReq = 1'b0; useBp = 1'b0;
        repeat (4) @(posedge clock);
        #1 ddrRst = 1'b0;
        @(negedge clock);
        checkOutput("rst_wreq", wreqA, 0);
        checkOutput("rst_waddr", waddrA, 0);
        checkOutput("rst_wdata", wdataA, 0);
        checkOutput("rst_ready", readyA, 0);
        checkOutput("rst_frame_bit", frameBitA, 0);
        checkOutput("rst_done", doneA, 0);
        checkOutput("rst_abort", abortA, 0);

        // Four-line frame, then the first line of the next bank.
        base = doneCnt;
        pulseFsync();
        expAddr = '{27'd0, 27'd24, 27'd48, 27'd72};
        fork
            applyStimulus(12, 200);
            serveBursts(4, -1);
        join
        repeat (3) @(negedge clock);
        checkOutput("frame_done_pulses", doneCnt - base, 1);
        checkOutput("frame_bit_toggled", frameBitA, 1);
        checkOutput("idle_ready", readyA, 0);
        pulseFsync();
        expAddr.push_back(27'h400000);
        fork
            applyStimulus(3, 100);
            serveBursts(1, -1);
        join

        // Sync during line 2's transfer: burst finishes, frame restarts in bank 0.
        doReset();
        base = abortCnt;
        baseW = doneCnt;
        pulseFsync();
        expAddr = '{27'd0, 27'd24, 27'd48};
        fork
            applyStimulus(12, 200);
            serveBursts(3, 2);
        join
        repeat (3) @(negedge clock);
        checkOutput("abort_pulses", abortCnt - base, 1);
        checkOutput("abort_no_done", doneCnt - baseW, 0);
        checkOutput("abort_frame_bit", frameBitA, 0);
        expData.delete();
        expAddr.push_back(27'd0);
        fork
            applyStimulus(3, 100);
            serveBursts(1, -1);
        join

        // Without calibration a sync edge is ignored.
        doReset();
        initDone = 1'b0;
        baseW = wreqCnt;
        pulseFsync();
        repeat (10) @(negedge clock);
        checkOutput("nocal_ready", readyA, 0);
        checkOutput("nocal_wreq", wreqCnt - baseW, 0);
        initDone = 1'b1;

        // Backpressure on the tall-frame DUT: fill to 1024, then drain in order.
        doReset();
        useBp = 1'b1;
        ddrWrdy = 1'b0;
        acceptedCnt = 0;
        pulseFsync();
        fork
            applyStimulus(1100, 4000);
            begin
                repeat (1150) @(negedge clock);
                checkOutput("bp_accepted", acceptedCnt, 1024);
                checkOutput("bp_ready_low", readyB, 0);
                @(posedge clock); #1 ddrWrdy = 1'b1;
                serveBursts(366, -1);
            end
        join
        checkOutput("bp_total_accepted", acceptedCnt, 1100);
        checkOutput("bp_leftover", expData.size(), 2);
        useBp = 1'b0;

`ifdef WR_BUF_ABORT_CNT_EN
        doReset();
        pulseFsync();
        repeat (2) pulseFsync();
        repeat (3) @(negedge clock);
        checkOutput("abort_cnt_two", abortCntA, 2);
        repeat (298) pulseFsync();
        repeat (3) @(negedge clock);
        checkOutput("abort_cnt_sat", abortCntA, 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/wr_line_buf.md
# wr_line_buf

Single-clock write-side line buffer for the PCIe 128-bit zero-copy path. It accepts a 128-bit pixel-beat stream from the PCIe/DMA side into a 1024-deep ring RAM. Once a full line is buffered it issues one DDR write burst, and it serves the controller's data-request beats from the RAM. At each completed frame it toggles the frame-bank bit that the DDR read path locks onto.

## Interface
- ADDR_WIDTH, 27: DDR address width.
- ADDR_OFFSET, 32'h0: base added to every burst address.
- H_NUM, 1920: pixels per line.
- V_NUM, 1080: lines per frame.
- DQ_WIDTH, 16: DDR DQ width; the DDR beat is 8*DQ_WIDTH = 128 bits.
- LEN_WIDTH, 16: burst-length width.
- PIX_WIDTH, 24: bits per pixel. H_NUM*PIX_WIDTH must be a multiple of 128.
- LINE_ADDR_WIDTH, 22: in-bank address width. ADDR_WIDTH ≥ LINE_ADDR_WIDTH+1.
- ddr_clk  in  1  sole clock.
- ddr_rst  in  1  synchronous, active-high reset.
- init_done  in  1  DDR calibration complete.
- vin_fsync  in  1  frame sync; its rising edge starts a frame.
- vin_valid  in  1  input beat valid.
- vin_ready  out  1  buffer accepts a beat.
- vin_data  in  128  input beat.
- ddr_wreq  out  1  burst request (level).
- ddr_waddr  out  ADDR_WIDTH  burst address.
- ddr_wr_len  out  LEN_WIDTH  beats per burst.
- ddr_wrdy  in  1  request accepted.
- ddr_wdone  in  1  burst complete; the rising edge is used.
- ddr_wdata_req  in  1  controller pulls one beat.
- ddr_wdata  out  8*DQ_WIDTH  write beat.
- o_wr_frame_bit  out  1  bank currently being written.
- o_frame_done  out  1  one-cycle pulse when a frame is complete.
- o_frame_abort  out  1  one-cycle pulse when a frame is abandoned.

## Operation
- Derived constants:
  - LINE_BEATS = H_NUM*PIX_WIDTH/128.
  - ADDR_STEP = LINE_BEATS*128/DQ_WIDTH.
  - ddr_wr_len = LINE_BEATS, constant.
- Pointers: 11-bit write/read pointers (10-bit RAM index plus wrap bit). fill = wptr − rptr, range 0..1024.
  - A push occurs on vin_valid & vin_ready; it advances wptr.
  - A pop occurs on ddr_wdata_req in XFER while beat_cnt < LINE_BEATS; it advances rptr.
  - Push and pop in the same cycle leave fill unchanged.
- vin_ready = (state ≠ IDLE) & ~restart_pend & (fill < 1024).
- ddr_waddr = {o_wr_frame_bit, line_addr} + ADDR_OFFSET.
  - line_addr advances by ADDR_STEP per line and wraps modulo 2^LINE_ADDR_WIDTH.
- FSM:
  - IDLE: on fsync rise & init_done, clear pointers, line_cnt and line_addr, then go to FILL. When init_done=0, fsync is ignored.
  - FILL: when fill ≥ LINE_BEATS, go to REQ.
  - REQ: ddr_wreq=1, held until ddr_wrdy=1 is sampled; then clear beat_cnt and go to XFER.
  - XFER: serve pops. On ddr_wdone rise, force rptr = burst start + LINE_BEATS and go to NEXT.
    - Extra requests beyond LINE_BEATS do not advance rptr.
    - An early wdone discards the unsent beats.
  - NEXT:
    - If restart_pend: pulse o_frame_abort, leave the frame bit unchanged, restart as from IDLE with fsync seen.
    - Else if line_cnt == V_NUM−1: pulse o_frame_done, toggle o_wr_frame_bit, go to IDLE.
    - Else: line_cnt++, line_addr += ADDR_STEP, go to FILL.
- Frame sync arriving mid-frame (fsync rise while not in IDLE):
  - In FILL: abort immediately (pulse o_frame_abort, flush, line 0).
  - In REQ/XFER: set restart_pend; the current burst finishes normally and the abort is handled in NEXT.
- ddr_rst mid-burst: everything returns to reset values immediately. The controller side is reset by the same signal.

## Timing
- Reset values: ddr_wreq 0, ddr_waddr ADDR_OFFSET, ddr_wdata 0, vin_ready 0, o_wr_frame_bit 0, o_frame_done 0, o_frame_abort 0, state IDLE.
- ddr_wdata is the registered RAM output, valid one cycle after the ddr_wdata_req cycle that popped it.
- A beat pushed in cycle N can be popped from cycle N+1.
- ddr_waddr is stable from REQ entry until ddr_wrdy.
- o_frame_done and o_frame_abort are registered and asserted in the cycle after NEXT.
- Minimum gap from the fsync edge to the first ddr_wreq: 1 cycle in IDLE plus LINE_BEATS pushes plus 1.

## Configuration
- WR_BUF_ABORT_CNT_EN defined: adds output o_abort_cnt[7:0].
  - Saturating count of o_frame_abort pulses.
  - Reset to 0 by ddr_rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package wr_line_buf_pkg holds:
  - state enum {IDLE, FILL, REQ, XFER, NEXT};
  - RAM_WIDTH=128 and BUF_DEPTH=1024;
  - functions deriving LINE_BEATS and ADDR_STEP.
- One sub-module, wr_line_ram: 1024×128 simple dual-port RAM, single clock, 1-cycle registered read.

## Test plan
- Reset: assert ddr_rst for 4 cycles → all outputs at reset values, vin_ready=0, no ddr_wreq.
- Small frame (H_NUM=16, PIX_WIDTH=24, V_NUM=4, so LINE_BEATS=3, ADDR_STEP=24), 12 beats pushed, ddr_wrdy tied 1 → four bursts, len 3, at addresses 0, 24, 48, 72, data in order. Then o_frame_done pulses and o_wr_frame_bit=1. The next frame's first address is 2^22.
- Backpressure: ddr_wrdy held 0 while 1100 beats are offered → vin_ready falls when fill=1024. After release, all 1024 beats appear on ddr_wdata unchanged.
- fsync rise during XFER of line 2 → the burst completes, o_frame_abort pulses, o_wr_frame_bit is unchanged, the next ddr_waddr=ADDR_OFFSET.
- init_done=0 plus an fsync rise → state stays IDLE, vin_ready=0, no requests.
- With WR_BUF_ABORT_CNT_EN: two aborts → o_abort_cnt=2. 300 aborts → o_abort_cnt=255.
